// File: rtl/mem_pkg.sv
// Shared widths and timing constants for the memory responder and its storage.
package mem_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 8;

    // Cycles from the dm_rd strobe cycle to the dm_rvalid cycle.
    localparam int unsigned RD_LATENCY = 2;

endpackage : mem_pkg

// File: rtl/sp_ram.sv
// Storage array with synchronous write and a registered, write-first read port.
// The read register holds when no read is requested and resets to zero; the array itself is never reset.
module sp_ram #(
    parameter int unsigned ADDR_W = mem_pkg::ADDR_W_DEF,
    parameter int unsigned DATA_W = mem_pkg::DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // Array write; contents survive reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Same-cycle write to the read address forwards the new data.
    always_comb begin
        rdata_d = rdata_q;
        if (re_i) begin
            if (we_i && (waddr_i == raddr_i)) begin
                rdata_d = wdata_i;
            end else begin
                rdata_d = mem_q[raddr_i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule : sp_ram

// File: rtl/memory_responder.sv
// Instruction and data memory responder: 1-cycle fetch, 2-cycle pipelined data reads,
// and a sticky flag for read/write strobe collisions.
module memory_responder
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              im_abus_valid,
    input  logic [ADDR_W-1:0] im_abus_data,
    output logic [DATA_W-1:0] im_data,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              dm_rd,
    input  logic              dm_wr,
    input  logic [ADDR_W-1:0] dm_abus,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_rvalid,
    output logic              err_collision
);

    logic                  imem_we_c;
    logic                  dmem_we_c;
    logic                  rd_issue_c;
    logic                  collision_c;
    logic [DATA_W-1:0]     s1_data;

    logic [RD_LATENCY-1:0] rd_vld_q;
    logic [RD_LATENCY-1:0] rd_vld_d;
    logic [DATA_W-1:0]     dm_rdata_q;
    logic [DATA_W-1:0]     dm_rdata_d;
    logic                  err_q;
    logic                  err_d;

    // Array writes are gated by reset so strobes seen during reset have no effect.
    assign imem_we_c   = prog_we & reset;
    assign dmem_we_c   = dm_wr & reset;
    assign rd_issue_c  = dm_rd & ~dm_wr;
    assign collision_c = dm_rd & dm_wr;

    sp_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_imem (
        .clk     (clk),
        .rst_n   (reset),
        .we_i    (imem_we_c),
        .waddr_i (prog_addr),
        .wdata_i (prog_data),
        .re_i    (im_abus_valid),
        .raddr_i (im_abus_data),
        .rdata_o (im_data)
    );

    // The dmem read register acts as read stage 1.
    sp_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_dmem (
        .clk     (clk),
        .rst_n   (reset),
        .we_i    (dmem_we_c),
        .waddr_i (dm_abus),
        .wdata_i (dm_wdata),
        .re_i    (rd_issue_c),
        .raddr_i (dm_abus),
        .rdata_o (s1_data)
    );

    // Valid shift: bit 0 tracks stage 1, the top bit is the output strobe.
    always_comb begin
        rd_vld_d   = {rd_vld_q[RD_LATENCY-2:0], rd_issue_c};
        dm_rdata_d = dm_rdata_q;
        err_d      = err_q | collision_c;
        if (rd_vld_q[0]) begin
            dm_rdata_d = s1_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_vld_q   <= '0;
            dm_rdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            rd_vld_q   <= rd_vld_d;
            dm_rdata_q <= dm_rdata_d;
            err_q      <= err_d;
        end
    end

    assign dm_rdata      = dm_rdata_q;
    assign dm_rvalid     = rd_vld_q[RD_LATENCY-1];
    assign err_collision = err_q;

endmodule : memory_responder

// File: tb/tb_memory_responder.sv
// Scoreboard bench for memory_responder: stimulus queues expected fetch/read results,
// a negedge monitor checks them against the DUT outputs.
module tb_memory_responder;

    logic       clk;
    logic       reset;
    logic       im_abus_valid;
    logic [7:0] im_abus_data;
    logic [7:0] im_data;
    logic       prog_we;
    logic [7:0] prog_addr;
    logic [7:0] prog_data;
    logic       dm_rd;
    logic       dm_wr;
    logic [7:0] dm_abus;
    logic [7:0] dm_wdata;
    logic [7:0] dm_rdata;
    logic       dm_rvalid;
    logic       err_collision;

    typedef struct {
        logic [7:0] d;
        int         cyc;
    } exp_t;

    exp_t dq[$];
    exp_t iq[$];
    int   cyc      = 0;
    int   n_cmp    = 0;
    int   n_err    = 0;
    int   rv_count = 0;

    memory_responder dut (
        .clk           (clk),
        .reset         (reset),
        .im_abus_valid (im_abus_valid),
        .im_abus_data  (im_abus_data),
        .im_data       (im_data),
        .prog_we       (prog_we),
        .prog_addr     (prog_addr),
        .prog_data     (prog_data),
        .dm_rd         (dm_rd),
        .dm_wr         (dm_wr),
        .dm_abus       (dm_abus),
        .dm_wdata      (dm_wdata),
        .dm_rdata      (dm_rdata),
        .dm_rvalid     (dm_rvalid),
        .err_collision (err_collision)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: compares queued expectations with what the DUT presents.
    always @(negedge clk) begin
        exp_t e;
        if (dm_rvalid) begin
            rv_count++;
            if (dq.size() == 0) begin
                check("unexpected_rvalid", 32'(dm_rdata), 32'hDEAD);
            end else begin
                e = dq.pop_front();
                check("rd_data", 32'(dm_rdata), 32'(e.d));
                check("rd_latency_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else if (dq.size() > 0 && dq[0].cyc <= cyc) begin
            e = dq.pop_front();
            check("rvalid_missing", 32'(dm_rvalid), 32'd1);
        end
        if (iq.size() > 0 && iq[0].cyc <= cyc) begin
            e = iq.pop_front();
            check("im_data", 32'(im_data), 32'(e.d));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        im_abus_valid = 1'b0;
        prog_we       = 1'b0;
        dm_rd         = 1'b0;
        dm_wr         = 1'b0;
    endtask

    task automatic prog(input logic [7:0] a, input logic [7:0] d);
        step();
        prog_we = 1'b1; prog_addr = a; prog_data = d;
    endtask

    task automatic fetch(input logic [7:0] a, input logic [7:0] exp);
        step();
        im_abus_valid = 1'b1; im_abus_data = a;
        iq.push_back('{exp, cyc + 1});
    endtask

    task automatic dwr(input logic [7:0] a, input logic [7:0] d);
        step();
        dm_wr = 1'b1; dm_abus = a; dm_wdata = d;
    endtask

    task automatic drd(input logic [7:0] a, input logic [7:0] exp);
        step();
        dm_rd = 1'b1; dm_abus = a;
        dq.push_back('{exp, cyc + 2});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int rv_before;
        reset = 1'b0;
        im_abus_valid = 1'b0; im_abus_data = '0;
        prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        dm_rd = 1'b0; dm_wr = 1'b0; dm_abus = '0; dm_wdata = '0;

        idle(3);
        @(negedge clk);
        check("rst_im_data", 32'(im_data), 32'h0);
        check("rst_dm_rdata", 32'(dm_rdata), 32'h0);
        check("rst_dm_rvalid", 32'(dm_rvalid), 32'h0);
        check("rst_err", 32'(err_collision), 32'h0);
        step();
        reset = 1'b1;

        // Instruction load, fetch, write-first and hold.
        prog(8'h05, 8'hA7);
        fetch(8'h05, 8'hA7);
        step();
        prog_we = 1'b1; prog_addr = 8'h06; prog_data = 8'h5E;
        im_abus_valid = 1'b1; im_abus_data = 8'h06;
        iq.push_back('{8'h5E, cyc + 1});
        step();
        iq.push_back('{8'h5E, cyc + 1});
        idle(1);

        // Write then read, back-to-back reads.
        dwr(8'h10, 8'h3C);
        drd(8'h10, 8'h3C);
        dwr(8'h00, 8'h11);
        dwr(8'h01, 8'h22);
        dwr(8'h02, 8'h33);
        drd(8'h00, 8'h11);
        drd(8'h01, 8'h22);
        drd(8'h02, 8'h33);
        // Later write must not disturb the in-flight read.
        drd(8'h01, 8'h22);
        dwr(8'h01, 8'h99);
        drd(8'h01, 8'h99);
        dwr(8'hFF, 8'hEE);
        drd(8'hFF, 8'hEE);
        idle(4);
        @(negedge clk);
        check("rdata_hold", 32'(dm_rdata), 32'hEE);

        // Collision: write happens, read dropped, flag sticks.
        rv_before = rv_count;
        step();
        dm_rd = 1'b1; dm_wr = 1'b1; dm_abus = 8'h20; dm_wdata = 8'h55;
        idle(4);
        @(negedge clk);
        check("collision_no_rvalid", 32'(rv_count), 32'(rv_before));
        check("err_set", 32'(err_collision), 32'h1);
        drd(8'h20, 8'h55);
        idle(4);
        @(negedge clk);
        check("err_sticky", 32'(err_collision), 32'h1);

        // Reset mid-read flushes the pipeline; strobes during reset ignored.
        rv_before = rv_count;
        step();
        dm_rd = 1'b1; dm_abus = 8'h10;
        step();
        reset = 1'b0;
        dm_wr = 1'b1; dm_abus = 8'h10; dm_wdata = 8'hFF;
        prog_we = 1'b1; prog_addr = 8'h05; prog_data = 8'h00;
        idle(3);
        @(negedge clk);
        check("flush_no_rvalid", 32'(rv_count), 32'(rv_before));
        check("mid_rst_im_data", 32'(im_data), 32'h0);
        check("mid_rst_dm_rdata", 32'(dm_rdata), 32'h0);
        check("mid_rst_err", 32'(err_collision), 32'h0);
        step();
        reset = 1'b1;
        drd(8'h10, 8'h3C);
        fetch(8'h05, 8'hA7);
        idle(1);

        for (int i = 0; i < 20 && (dq.size() > 0 || iq.size() > 0); i++) idle(1);
        check("drain_dq_empty", 32'(dq.size()), 32'h0);
        check("drain_iq_empty", 32'(iq.size()), 32'h0);
        @(negedge clk);
        check("final_err_clear", 32'(err_collision), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_memory_responder

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the address width of both memories.
REQ-002 Parameter DATA_W, default 8, SHALL set the data width of both memories.
REQ-003 Port clk  in  1: single clock; all state SHALL update on its rising edge.
REQ-004 Port reset  in  1: asynchronous, active-low reset; 0 SHALL reset all control state immediately, independent of clk.
REQ-005 Port im_abus_valid  in  1: instruction fetch strobe.
REQ-006 Port im_abus_data  in  ADDR_W: instruction fetch address.
REQ-007 Port im_data  out  DATA_W: fetched instruction word.
REQ-008 Port prog_we  in  1: instruction memory load strobe.
REQ-009 Port prog_addr  in  ADDR_W and prog_data  in  DATA_W: instruction memory load address and data.
REQ-010 Port dm_rd  in  1 and dm_wr  in  1: data memory read and write strobes.
REQ-011 Port dm_abus  in  ADDR_W: data memory address.
REQ-012 Port dm_wdata  in  DATA_W: data memory write data.
REQ-013 Port dm_rdata  out  DATA_W: data memory read data.
REQ-014 Port dm_rvalid  out  1: single-cycle pulse marking dm_rdata as new.
REQ-015 Port err_collision  out  1: sticky flag for simultaneous dm_rd and dm_wr.

Function
REQ-016 Fetch: im_abus_valid=1 at edge T SHALL load im_data with imem[im_abus_data] at edge T (1-cycle latency); im_data SHALL hold when im_abus_valid=0.
REQ-017 Load: prog_we=1 SHALL write prog_data to imem[prog_addr]; fetch and load to the same address in one cycle SHALL return prog_data (write-first).
REQ-018 Data write: dm_wr=1 at edge T SHALL write dm_wdata to dmem[dm_abus] at edge T.
REQ-019 Data read: dm_rd=1 (dm_wr=0) at edge T SHALL sample dmem[dm_abus] into stage 1 at T; the value SHALL reach dm_rdata at edge T+1, with dm_rvalid=1 for that cycle only.
REQ-020 Read latency: dm_rvalid SHALL rise exactly 2 cycles after the cycle in which dm_rd is asserted, matching the initiator's two-stage read capture.
REQ-021 Throughput: back-to-back reads on consecutive cycles SHALL produce dm_rvalid on consecutive cycles, in issue order, with no bubbles.
REQ-022 Ordering: a write issued after a read SHALL NOT change that in-flight read's result.
REQ-023 dm_rdata SHALL hold its last value while dm_rvalid=0.
REQ-024 Collision: dm_rd=1 and dm_wr=1 in the same cycle SHALL perform the write, drop the read (no dm_rvalid), and set err_collision.
REQ-025 err_collision SHALL stay set until reset.
REQ-026 Addresses SHALL wrap modulo 2^ADDR_W; there SHALL be no out-of-range condition.

Reset
REQ-027 While reset=0: im_data=0, dm_rdata=0, dm_rvalid=0, err_collision=0, and the read pipeline valid bits SHALL be cleared.
REQ-028 Reset asserted mid-read SHALL flush the pipeline: no dm_rvalid for reads issued before reset.
REQ-029 Memory array contents SHALL NOT be cleared by reset.
REQ-030 Strobes sampled while reset=0 SHALL be ignored; the first edge after release SHALL accept strobes.

Structure
REQ-031 ADDR_W/DATA_W defaults and the read latency constant (2) SHALL live in a shared package mem_pkg.
REQ-032 Storage SHALL use one sub-module, sp_ram (synchronous write, write-first read), instantiated twice: once as imem, once as dmem.
REQ-033 The read pipeline and collision logic SHALL reside in memory_responder.

Verification
REQ-034 Reset, then prog_we at addr 0x05 with data 0xA7; fetch 0x05 -> im_data=0xA7 one cycle after the fetch strobe.
REQ-035 dm_wr at addr 0x10 with data 0x3C, then dm_rd at 0x10 -> dm_rvalid pulse exactly 2 cycles later with dm_rdata=0x3C.
REQ-036 Reads of 0x00, 0x01, 0x02 on consecutive cycles (preloaded 0x11, 0x22, 0x33) -> three consecutive dm_rvalid pulses carrying 0x11, 0x22, 0x33.
REQ-037 dm_rd and dm_wr together at 0x20 with data 0x55 -> no dm_rvalid, err_collision=1 and stays set, and a later read of 0x20 returns 0x55.
REQ-038 dm_rd at 0x10, then reset pulsed low on the next cycle -> no dm_rvalid; all outputs 0; after release, a read of 0x10 still returns 0x3C.
